// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: scoreboard entries,
// memory-wait FSM states and the bundled stage-register control word.
package pipe_ctrl_pkg;

    // One in-flight destination register: valid flag plus register index.
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
    } sb_entry_t;

    // Data-memory handshake tracker.
    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

    // Enable and flush pins of the PC and the four stage registers.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
    } ctrl_t;

    localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: 5'd0};

    // Everything advances, nothing is flushed.
    localparam ctrl_t CTRL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        mem_wb_en: 1'b1, if_id_flush: 1'b0, id_ex_flush: 1'b0,
        mem_wb_flush: 1'b0
    };

    // Held in reset: nothing loads, every stage register is flushed.
    localparam ctrl_t CTRL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        mem_wb_en: 1'b0, if_id_flush: 1'b1, id_ex_flush: 1'b1,
        mem_wb_flush: 1'b1
    };

    // A source register collides with an entry only if it is a real
    // register (x0 is hardwired) and the entry is live.
    function automatic logic sb_match(input sb_entry_t e, input logic [4:0] rs);
        return e.v && (e.rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Three-entry shift register of in-flight destinations (EX, MEM, WB) with
// combinational read-after-write match outputs for the two ID sources.
module pipe_scoreboard
    import pipe_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      bubble,
    input  sb_entry_t new_entry,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    output logic      rs1_hit,
    output logic      rs2_hit
);

    sb_entry_t ex_e;
    sb_entry_t mem_e;
    sb_entry_t wb_e;

    // Shift entries toward WB; a hold keeps EX/MEM and retires WB.
    // NOTE: non-blocking assignments let every entry sample the old value of
    // its neighbour, so the three stages shift in one edge without ordering
    // hazards between statements.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_e  <= SB_EMPTY;
            mem_e <= SB_EMPTY;
            wb_e  <= SB_EMPTY;
        end else if (hold) begin
            wb_e  <= SB_EMPTY;
        end else begin
            ex_e  <= bubble ? SB_EMPTY : new_entry;
            mem_e <= ex_e;
            wb_e  <= mem_e;
        end
    end

    assign rs1_hit = sb_match(ex_e, rs1) || sb_match(mem_e, rs1) || sb_match(wb_e, rs1);
    assign rs2_hit = sb_match(ex_e, rs2) || sb_match(mem_e, rs2) || sb_match(wb_e, rs2);

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: RAW hazard stalls,
// data-memory wait freezes with timeout, and redirect flushes.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       id_rd,
    input  logic             id_wb_en,
    input  logic             id_redirect,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] TMO_LIMIT = 4'(MEM_TIMEOUT);

    mem_state_t state;
    mem_state_t state_nx;
    logic [3:0] tmo_cnt;
    logic       freeze;
    logic       tmo_hit;
    logic       raw;
    logic       stall;
    logic       sb_hold;
    logic       sb_bubble;
    logic       rs1_hit;
    logic       rs2_hit;
    sb_entry_t  new_entry;
    ctrl_t      ctrl;

    assign new_entry = '{v: id_valid && id_wb_en && (id_rd != 5'd0), rd: id_rd};

    pipe_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .hold      (sb_hold),
        .bubble    (sb_bubble),
        .new_entry (new_entry),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .rs1_hit   (rs1_hit),
        .rs2_hit   (rs2_hit)
    );

    assign raw = id_valid && ((id_rs1_used && rs1_hit) || (id_rs2_used && rs2_hit));

    // Memory FSM next state: freeze while a request is outstanding. Once the
    // counter has seen MEM_TIMEOUT frozen WAIT cycles the access is abandoned
    // and that cycle advances the pipe.
    // NOTE: every signal gets a default before the case, so no path leaves a
    // combinational output unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        freeze   = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req && !mem_ack) begin
                    freeze   = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_nx = IDLE;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    tmo_hit  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Priority resolution of freeze, EX redirect, RAW stall and ID redirect.
    always_comb begin
        ctrl      = CTRL_RUN;
        sb_hold   = 1'b0;
        sb_bubble = 1'b0;
        stall     = 1'b0;
        if (!rst) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            // Redirects are ignored: EX is frozen and re-presents them later.
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_en    = 1'b0;
            ctrl.mem_wb_flush = 1'b1;
            sb_hold           = 1'b1;
            stall             = 1'b1;
        end else if (ex_redirect) begin
            // A coincident RAW stall is moot: the stalled instruction is discarded.
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            sb_bubble        = 1'b1;
        end else if (raw) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            sb_bubble        = 1'b1;
            stall            = 1'b1;
        end else if (id_redirect) begin
            ctrl.if_id_flush = 1'b1;
        end
    end

    // FSM, timeout counter, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= 4'd0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state   <= state_nx;
            tmo_cnt <= (state == WAIT && state_nx == WAIT) ? tmo_cnt + 4'd1 : 4'd0;
            mem_err <= mem_err || tmo_hit;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign if_id_en     = ctrl.if_id_en;
    assign id_ex_en     = ctrl.id_ex_en;
    assign ex_mem_en    = ctrl.ex_mem_en;
    assign mem_wb_en    = ctrl.mem_wb_en;
    assign if_id_flush  = ctrl.if_id_flush;
    assign id_ex_flush  = ctrl.id_ex_flush;
    assign mem_wb_flush = ctrl.mem_wb_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl: RAW stalls at each producer distance,
// x0 immunity, memory freeze and timeout, redirects, counter saturation and
// reset mid-WAIT. Control word order: pc,if_id,id_ex,ex_mem,mem_wb enables,
// then if_id,id_ex,mem_wb flushes.
module tb_pipe_ctrl;

    localparam int CNT_W = 5;

    localparam logic [7:0] C_NORM = 8'b11111_000;
    localparam logic [7:0] C_FRZ  = 8'b00001_001;
    localparam logic [7:0] C_EXR  = 8'b11111_110;
    localparam logic [7:0] C_RAW  = 8'b00111_010;
    localparam logic [7:0] C_IDR  = 8'b11111_100;
    localparam logic [7:0] C_RST  = 8'b00000_111;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       id_rd;
    logic             id_wb_en;
    logic             id_redirect;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ack;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1_used  (id_rs1_used),
        .id_rs2_used  (id_rs2_used),
        .id_rd        (id_rd),
        .id_wb_en     (id_wb_en),
        .id_redirect  (id_redirect),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_flush (mem_wb_flush),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present an ID instruction.
    task automatic id_in(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wb);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_wb_en    = wb;
    endtask

    task automatic mem_in(input logic req, input logic ack);
        mem_req = req;
        mem_ack = ack;
    endtask

    // Check the control word mid-cycle, then step past the next rising edge.
    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {24'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, mem_wb_flush}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic stat(input string tag, input int cnt, input logic err);
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(cnt));
        check({tag, "_err"}, {31'd0, mem_err}, {31'd0, err});
    endtask

    initial begin
        rst = 1'b0;
        id_redirect = 1'b0;
        ex_redirect = 1'b0;
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_in(1'b0, 1'b0);
        @(posedge clk);
        #1;
        cyc("reset_ctrl", C_RST);
        stat("reset", 0, 1'b0);
        rst = 1'b1;

        // addi x5 then add x6,x5,x5: three stall cycles, then issue.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        cyc("raw_prod", C_NORM);
        id_in(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) cyc("raw_ex_stall", C_RAW);
        cyc("raw_issue", C_NORM);
        stat("raw3", 3, 1'b0);

        // Writes to x0 never hazard.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        cyc("x0_prod", C_NORM);
        id_in(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        cyc("x0_cons", C_NORM);
        stat("x0", 3, 1'b0);

        // Producer already in WB: one stall cycle.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
        cyc("wb_prod", C_NORM);
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("wb_gap1", C_NORM);
        cyc("wb_gap2", C_NORM);
        id_in(1'b1, 5'd1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        cyc("wb_stall", C_RAW);
        cyc("wb_issue", C_NORM);
        stat("wb1", 4, 1'b0);

        // Memory wait: ack after 4 WAIT cycles -> 5 frozen; x9 held in EX.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        cyc("mem_prod", C_NORM);
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_in(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc("mem_freeze", C_FRZ);
        mem_in(1'b1, 1'b1);
        cyc("mem_ack", C_NORM);
        stat("mem", 9, 1'b0);
        mem_in(1'b0, 1'b0);
        id_in(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("mem_held1", C_RAW);
        cyc("mem_held2", C_RAW);
        cyc("mem_held_issue", C_NORM);
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_in(1'b1, 1'b1);
        cyc("mem_fast_ack", C_NORM);
        mem_in(1'b0, 1'b0);
        stat("mem_fast", 11, 1'b0);

        // ex_redirect during a RAW stall on x7 becomes a flush.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cyc("exr_prod", C_NORM);
        id_in(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("exr_stall", C_RAW);
        ex_redirect = 1'b1;
        cyc("exr_flush", C_EXR);
        ex_redirect = 1'b0;
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("exr_after", C_NORM);
        stat("exr", 12, 1'b0);

        // JAL in ID issues with an IF/ID flush; a RAW stall beats id_redirect.
        id_redirect = 1'b1;
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
        cyc("idr_jal", C_IDR);
        id_redirect = 1'b0;
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc("idr_prod", C_NORM);
        id_redirect = 1'b1;
        id_in(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("idr_vs_raw", C_RAW);
        id_redirect = 1'b0;
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc("idr_drain", C_NORM);
        stat("idr", 13, 1'b0);

        // No ack: 1 IDLE + 15 WAIT frozen cycles, then the pipe advances.
        mem_in(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc("tmo_freeze", C_FRZ);
        cyc("tmo_advance", C_NORM);
        mem_in(1'b0, 1'b0);
        stat("tmo", 29, 1'b1);
        cyc("tmo_idle", C_NORM);

        // Stall counter saturates at all-ones (5-bit instance).
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1);
        cyc("sat_prod", C_NORM);
        id_in(1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
        cyc("sat_stall1", C_RAW);
        stat("sat30", 30, 1'b1);
        cyc("sat_stall2", C_RAW);
        cyc("sat_stall3", C_RAW);
        stat("sat31", 31, 1'b1);
        cyc("sat_issue", C_NORM);

        // Reset asserted mid-WAIT abandons the access and clears everything.
        id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        cyc("rw_prod", C_NORM);
        id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        mem_in(1'b1, 1'b0);
        cyc("rw_freeze_idle", C_FRZ);
        cyc("rw_freeze_wait", C_FRZ);
        rst = 1'b0;
        cyc("rw_reset", C_RST);
        stat("rw_reset", 0, 1'b0);
        rst = 1'b1;
        mem_in(1'b0, 1'b0);
        id_in(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("rw_idle_sb_clear", C_NORM);
        stat("rw_after", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline (IF, ID, EX, MEM, WB). It tracks in-flight destination registers to detect read-after-write hazards, because there is no forwarding and the regfile has no write-through. It also waits on a handshaked data memory and converts branch/jump redirects into flushes. Its outputs drive the enable/flush pins of the PC and the four stage registers; it holds no datapath values.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max WAIT cycles before abandoning a memory access; 4-bit timeout counter.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1 / id_rs2  in  5  source register indices in ID
- id_rs1_used / id_rs2_used  in  1  source actually read
- id_rd  in  5  destination index in ID
- id_wb_en  in  1  ID instruction writes rd
- id_redirect  in  1  JAL decoded in ID (PC loads target)
- ex_redirect  in  1  taken branch/JALR resolved in EX
- mem_req  in  1  MEM stage holds load/store
- mem_ack  in  1  memory completes this cycle
- pc_en  out  1  PC may update
- if_id_en / id_ex_en / ex_mem_en / mem_wb_en  out  1  stage register load enables
- if_id_flush / id_ex_flush / mem_wb_flush  out  1  load zero (bubble) into the stage register
- mem_err  out  1  sticky, set on memory timeout
- stall_cnt  out  CNT_W  saturating count of non-advancing cycles

## Operation
- Scoreboard: three entries {v, rd} for EX, MEM and WB. rd==0 never sets v. A source hazards when it is used, id_valid is high, rs!=0, and rs matches a valid entry.
- Memory FSM states: IDLE and WAIT.
  - IDLE: mem_req & !mem_ack causes freeze this cycle and a move to WAIT. mem_req & mem_ack causes no stall.
  - WAIT: freeze until mem_ack, then advance and return to IDLE. The timeout counter increments on every WAIT cycle. When it reaches MEM_TIMEOUT, mem_err sets, the pipe advances and the FSM returns to IDLE.
- Priority, per cycle, highest first:
  1. freeze (mem wait): pc/if_id/id_ex/ex_mem enables 0; mem_wb_flush 1. Scoreboard EX and MEM hold, WB cleared. Redirect inputs are ignored because EX is frozen and re-presents them afterwards.
  2. ex_redirect: all enables 1; if_id_flush and id_ex_flush 1. The EX entry gets a bubble, MEM<=EX, WB<=MEM.
  3. raw stall: pc_en and if_id_en 0; id_ex_flush 1; ex_mem and mem_wb enables 1. EX entry bubble, shift continues.
  4. id_redirect: all enables 1; if_id_flush 1. The ID instruction (the JAL) issues normally.
  5. normal: all enables 1, no flushes. EX <= {id_valid & id_wb_en & id_rd!=0, id_rd}, MEM<=EX, WB<=MEM.
- stall_cnt increments on freeze or raw-stall cycles and saturates at all-ones.
- While rst=0:
  - Scoreboard entries are invalid, the FSM is IDLE, and the timeout counter, stall_cnt and mem_err are 0.
  - All enables are 0 and all flushes are 1.
  - Reset mid-WAIT abandons the access.

## Timing
- Hazard and freeze outputs are combinational from the current state and inputs, with zero-cycle latency. All state updates on the rising edge of clk.
- RAW stall length by producer position: EX gives 3 cycles, MEM gives 2, WB gives 1. The consumer issues on the cycle after the WB entry retires.
- Memory access with ack in the request cycle costs 0 stall cycles. Ack after N WAIT cycles costs N+1 frozen cycles total.
- A raw stall coincident with ex_redirect resolves as a flush: the stalled ID instruction is discarded.
- id_redirect coincident with a raw stall is impossible, since JAL reads no rs. If asserted anyway, the raw stall wins.

## Structure
- Package pipe_ctrl_pkg holds:
  - the sb_entry_t struct {v, rd[4:0]};
  - the mem_state_t enum {IDLE, WAIT};
  - the ctrl_t struct bundling the enable and flush outputs.
- Sub-module pipe_scoreboard holds the 3-entry shift register with hold/bubble/shift controls and two combinational match outputs. The FSM, priority logic and counters stay in pipe_ctrl.

## Test plan
- `addi x5` then dependent `add x6,x5,x5`: exactly 3 cycles with pc_en=0 and id_ex_flush=1; stall_cnt=3; the consumer then issues.
- Producer writes x0, then a consumer reads x0: no stall; stall_cnt stays 0.
- mem_req held with mem_ack on the 4th WAIT cycle: 5 frozen cycles with mem_wb_flush=1; the scoreboard EX/MEM entries are unchanged afterwards.
- mem_req with no ack: mem_err rises after 15 WAIT cycles and the pipe advances; mem_err stays 1 until rst=0.
- ex_redirect during a raw stall on x7: if_id_flush=id_ex_flush=1 and pc_en=1 that cycle; next cycle no stall.
- rst=0 asserted mid-WAIT: next cycle the FSM is IDLE, stall_cnt=0, mem_err=0, and all scoreboard entries are invalid.
